rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single-port program ROM between two requesters: the instruction-fetch sequencer (port F) and a table-read/debug reader (port T).
- Owns the registered ROM address (MAR-equivalent) and the returned-data registers.
- Round-robin arbitration sustains one ROM access per cycle, with fixed one-cycle read latency.
- Sits between the fetch/control FSM and the combinational ROM.

Parameters:
- ADDR_W, 11, ROM address width (2K words).
- DATA_W, 14, ROM word / instruction width.

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- reset  in  1  reset, asynchronous, active-high.
- f_req  in  1  fetch port request.
- f_addr  in  ADDR_W  fetch port word address; must be stable while f_req is high.
- f_gnt  out  1  fetch request accepted this cycle (combinational).
- f_rvalid  out  1  one-cycle pulse: f_rdata holds the data for the last accepted fetch request.
- f_rdata  out  DATA_W  fetch port read data (registered, held).
- t_req  in  1  table port request.
- t_addr  in  ADDR_W  table port address; must be stable while t_req is high.
- t_gnt  out  1  table request accepted this cycle (combinational).
- t_rvalid  out  1  one-cycle pulse: t_rdata valid.
- t_rdata  out  DATA_W  table port read data (registered, held).
- rom_addr  out  ADDR_W  registered address driven to ROM.
- rom_data  in  DATA_W  combinational ROM output for rom_addr.
- busy  out  1  high while a read is in flight (state READ).

Behaviour:
- Reset values: rom_addr=0, f_rdata=0, t_rdata=0, f_rvalid=0, t_rvalid=0, state=IDLE, owner=F, prio=F (fetch favoured), busy=0.
- States:
  - IDLE: no read in flight.
  - READ: rom_addr was latched on the previous edge; rom_data is valid this cycle.
- Handshake: a request is accepted on the falling edge where req&gnt=1. The requester may drop req or change addr only after that edge. Each req&gnt edge yields exactly one rvalid.
- Grant logic (combinational; evaluated in both IDLE and READ):
  - Only one request pending: that port is granted.
  - Both pending: the port equal to prio is granted.
  - No request: neither port is granted.
  - f_gnt and t_gnt are never both 1.
- On an accepting edge:
  - rom_addr <= winner's addr.
  - owner <= winner.
  - prio <= the non-winner.
  - state <= READ.
- In READ, at the edge:
  - Capture rom_data into the owner's rdata register.
  - Pulse the owner's rvalid for the following cycle.
  - The other port's rdata is unchanged.
  - If a new request is accepted at the same edge, stay in READ (back-to-back, 1 access/cycle); otherwise go to IDLE.
- Latency: request accepted at edge N → rvalid high for the cycle following edge N+1 (two falling edges after accept), rdata = ROM[addr].
- Simultaneous: a data capture for port X and a new grant to port X on the same edge are both legal. rvalid stays high for consecutive cycles, each cycle carrying new data.
- Fairness: with both requests held continuously, grants alternate F,T,F,T…; neither port waits more than one grant.
- Width: addresses pass through unmodified; there is no arithmetic. Address 2^ADDR_W-1 is legal.
- rvalid outputs are registered pulses, low in every cycle with no capture.
- Reset mid-operation: any in-flight read is dropped, no rvalid is issued, and all registers return to reset values immediately (asynchronous). prio returns to F.
- busy=1 exactly when state=READ.

Test Plan:
- Reset, then f_req=1, f_addr=0x005, ROM[5]=0x2ABC → f_gnt=1 at accept edge; two edges later f_rvalid=1 for one cycle, f_rdata=0x2ABC; t_rvalid stays 0.
- f_req and t_req both held, f_addr=0x010, t_addr=0x7FF → grants alternate F,T,F,T starting with F after reset; rvalid pulses alternate per port on consecutive cycles; rom_addr alternates 0x010/0x7FF.
- Back-to-back fetch of 0x000,0x001,0x002 with req held and addr advanced after each gnt → f_rvalid high 3 consecutive cycles, data ROM[0],ROM[1],ROM[2]; busy stays 1 throughout.
- Table read of 0x100 followed by idle → t_rdata holds ROM[0x100] after t_rvalid drops; later fetch reads do not alter t_rdata.
- Assert reset in the READ state after f accept → no f_rvalid, f_rdata=0, rom_addr=0, busy=0; next simultaneous request grants F first.
- No requests for 10 cycles → f_gnt=t_gnt=0, busy=0, rom_addr unchanged.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter that shares the single-port program ROM between the
// instruction-fetch port (F) and the table/debug read port (T). It owns the
// registered ROM address and the per-port read-data registers, and sustains
// one ROM access per cycle with a fixed one-cycle read latency.
// All state changes on the falling edge of clk.
module rom_port_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              t_req,
  input  logic [ADDR_W-1:0] t_addr,
  output logic              t_gnt,
  output logic              t_rvalid,
  output logic [DATA_W-1:0] t_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,  // no read in flight
    READ = 1'b1   // rom_addr latched last edge; rom_data valid this cycle
  } state_e;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_T = 1'b1
  } port_e;

  state_e state;
  port_e  owner;  // port whose read is currently in flight
  port_e  prio;   // port favoured when both request

  // Grant: a lone requester always wins; on contention the favoured port wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    f_gnt = 1'b0;
    t_gnt = 1'b0;
    if (f_req && (!t_req || prio == PORT_F)) begin
      f_gnt = 1'b1;
    end else if (t_req) begin
      t_gnt = 1'b1;
    end
  end

  assign busy = (state == READ);

  // Falling-edge sequencer: capture the in-flight read, then launch the next.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= PORT_F;
      prio     <= PORT_F;
      rom_addr <= '0;
      f_rdata  <= '0;
      t_rdata  <= '0;
      f_rvalid <= 1'b0;
      t_rvalid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the capture below use the owner of
      // the read in flight while the same edge hands ownership to a new winner.
      f_rvalid <= 1'b0;
      t_rvalid <= 1'b0;

      if (state == READ) begin
        if (owner == PORT_F) begin
          f_rdata  <= rom_data;
          f_rvalid <= 1'b1;
        end else begin
          t_rdata  <= rom_data;
          t_rvalid <= 1'b1;
        end
      end

      if (f_gnt) begin
        rom_addr <= f_addr;
        owner    <= PORT_F;
        prio     <= PORT_T;
        state    <= READ;
      end else if (t_gnt) begin
        rom_addr <= t_addr;
        owner    <= PORT_T;
        prio     <= PORT_F;
        state    <= READ;
      end else begin
        state    <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter. A behavioural model tracks the
// expected grants and a queue of outstanding reads with their due cycles;
// the ROM is an array in the bench driven combinationally from rom_addr.
module tb_rom_port_arbiter;

  localparam int AW = 11;
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          t_req = 1'b0;
  logic [AW-1:0] t_addr = '0;
  logic          t_gnt;
  logic          t_rvalid;
  logic [DW-1:0] t_rdata;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          busy;

  logic [DW-1:0] rom_mem [2**AW];
  assign rom_data = rom_mem[rom_addr];

  rom_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .t_req    (t_req),
    .t_addr   (t_addr),
    .t_gnt    (t_gnt),
    .t_rvalid (t_rvalid),
    .t_rdata  (t_rdata),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    bit            is_t;
    logic [DW-1:0] data;
    int            due;
  } resp_t;

  resp_t         pend_q[$];
  int            cyc = 0;
  bit            t_won_last = 1'b1;  // T won last => F favoured (reset state)
  logic [DW-1:0] exp_frd = '0;
  logic [DW-1:0] exp_trd = '0;
  logic [AW-1:0] exp_rom_addr = '0;
  logic          exp_busy = 1'b0;
  bit            got_f = 1'b0;
  bit            got_t = 1'b0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: check registered outputs at the rising edge, drive
  // inputs, check grants, then predict what the coming falling edge does.
  task automatic step(input logic fr, input logic [AW-1:0] fa,
                      input logic tr, input logic [AW-1:0] ta);
    resp_t r;
    logic  exp_fv, exp_tv, eg_f, eg_t;
    @(posedge clk);
    cyc++;
    exp_fv = 1'b0;
    exp_tv = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      r = pend_q.pop_front();
      if (r.is_t) begin
        exp_tv  = 1'b1;
        exp_trd = r.data;
      end else begin
        exp_fv  = 1'b1;
        exp_frd = r.data;
      end
    end
    check("f_rvalid", 32'(f_rvalid), 32'(exp_fv));
    check("t_rvalid", 32'(t_rvalid), 32'(exp_tv));
    check("f_rdata", 32'(f_rdata), 32'(exp_frd));
    check("t_rdata", 32'(t_rdata), 32'(exp_trd));
    check("busy", 32'(busy), 32'(exp_busy));
    check("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));

    f_req  = fr;
    f_addr = fa;
    t_req  = tr;
    t_addr = ta;
    #1;
    eg_f = fr && (!tr || t_won_last);
    eg_t = tr && (!fr || !t_won_last);
    check("f_gnt", 32'(f_gnt), 32'(eg_f));
    check("t_gnt", 32'(t_gnt), 32'(eg_t));

    got_f    = eg_f;
    got_t    = eg_t;
    exp_busy = eg_f || eg_t;
    if (eg_f || eg_t) begin
      r.is_t       = eg_t;
      r.data       = eg_t ? rom_mem[ta] : rom_mem[fa];
      r.due        = cyc + 2;
      exp_rom_addr = eg_t ? ta : fa;
      t_won_last   = eg_t;
      pend_q.push_back(r);
    end
  endtask

  // Asynchronous reset pulse launched mid-cycle, held across one falling edge.
  task automatic do_reset();
    @(posedge clk);
    cyc++;
    check("pre_reset_busy", 32'(busy), 32'(exp_busy));
    #2;
    reset = 1'b1;
    f_req = 1'b0;
    t_req = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_f_rdata", 32'(f_rdata), 32'd0);
    pend_q.delete();
    t_won_last   = 1'b1;
    exp_frd      = '0;
    exp_trd      = '0;
    exp_rom_addr = '0;
    exp_busy     = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    bit            fp, tp;
    logic [AW-1:0] fa, ta;

    for (int i = 0; i < 2**AW; i++) rom_mem[i] = DW'($urandom);
    rom_mem[5] = 14'h2ABC;

    // Power-on reset across two falling edges.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;

    // Single fetch of 0x005.
    step(1'b1, 11'h005, 1'b0, 11'h000);
    check("single_f_gnt", 32'(got_f), 32'd1);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    check("single_f_data", 32'(f_rdata), 32'h2ABC);
    step(1'b0, 11'h000, 1'b0, 11'h000);

    // Both held: alternate F,T,F,T starting with F after reset.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 11'h010, 1'b1, 11'h7FF);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    step(1'b0, 11'h000, 1'b0, 11'h000);

    // Back-to-back fetches of 0,1,2.
    for (int i = 0; i < 3; i++) step(1'b1, AW'(i), 1'b0, 11'h000);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    step(1'b0, 11'h000, 1'b0, 11'h000);

    // Table read of 0x100, idle, then fetches that must not disturb t_rdata.
    step(1'b0, 11'h000, 1'b1, 11'h100);
    for (int i = 0; i < 3; i++) step(1'b0, 11'h000, 1'b0, 11'h000);
    check("t_hold", 32'(t_rdata), 32'(rom_mem[11'h100]));
    step(1'b1, 11'h020, 1'b0, 11'h000);
    step(1'b1, 11'h021, 1'b0, 11'h000);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    step(1'b0, 11'h000, 1'b0, 11'h000);

    // Reset while READ after an F accept; next contention must grant F.
    step(1'b1, 11'h005, 1'b0, 11'h000);
    do_reset();
    step(1'b0, 11'h000, 1'b0, 11'h000);
    step(1'b1, 11'h033, 1'b1, 11'h044);
    check("post_reset_f_first", 32'(got_f), 32'd1);
    step(1'b0, 11'h000, 1'b1, 11'h044);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    step(1'b0, 11'h000, 1'b0, 11'h000);

    // Ten idle cycles.
    for (int i = 0; i < 10; i++) step(1'b0, 11'h000, 1'b0, 11'h000);

    // Randomised traffic obeying the hold-until-granted rule.
    fp = 1'b0;
    tp = 1'b0;
    fa = '0;
    ta = '0;
    for (int i = 0; i < 400; i++) begin
      if (!fp && $urandom_range(1, 0) == 1) begin
        fp = 1'b1;
        fa = ($urandom_range(7, 0) == 0) ? 11'h7FF : AW'($urandom);
      end
      if (!tp && $urandom_range(1, 0) == 1) begin
        tp = 1'b1;
        ta = ($urandom_range(7, 0) == 0) ? 11'h7FF : AW'($urandom);
      end
      step(fp, fa, tp, ta);
      if (got_f) fp = 1'b0;
      if (got_t) tp = 1'b0;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 11'h000, 1'b0, 11'h000);
    check("queue_drained", 32'(pend_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
